relu_pack8: RTL and testbench
=============================

RELU_PACK8 -- requirements
Module: relu_pack8

Interface
REQ-001 SHALL have parameter SHIFT, default 2: arithmetic right-shift amount used for requantization, legal range 0-4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: in_neuron/in_bias hold a valid neuron result.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a neuron result this cycle.
REQ-006 SHALL have port in_neuron, input, 12 bits signed: raw dot-product result from the 8-input sparse neuron stage.
REQ-007 SHALL have port in_bias, input, 12 bits signed: bias for the current neuron, sampled with in_neuron.
REQ-008 SHALL have port out_valid, output, 1 bit: packed activation vector is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream consumer accepts the vector.
REQ-010 SHALL have port out_act, output, 72 bits: eight 9-bit signed activations; slot k occupies bits [9k+8:9k].
REQ-011 SHALL have port out_nz, output, 8 bits: bit k = 1 iff slot k is non-zero (activation index bitmap for the next layer).
REQ-012 SHALL have port out_sat, output, 8 bits: bit k = 1 iff slot k was clipped to 255.

Function
REQ-013 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL define an input handshake as in_valid=1 and in_ready=1 on a rising edge; no other input cycle alters state.
REQ-015 SHALL, per handshake, compute sum = in_neuron + in_bias at 13-bit signed width, with no wrap-around.
REQ-016 SHALL apply ReLU: r = 0 if sum < 0, else sum.
REQ-017 SHALL compute q = r >>> SHIFT, truncating toward zero with no rounding.
REQ-018 SHALL clip q > 255 to 255 and set the slot's sat bit; otherwise the sat bit is 0.
REQ-019 SHALL write the result into slot cnt, where a 3-bit counter cnt starts at 0; the first accepted result goes to slot 0.
REQ-020 SHALL write the slot's nz bit in the same cycle as its activation.
REQ-021 SHALL increment cnt on each handshake; on the handshake with cnt=7, cnt SHALL wrap to 0 and the FSM SHALL enter HOLD.
REQ-022 SHALL assert out_valid on the first cycle after the 8th handshake; latency from the last input handshake to out_valid is 1 cycle.
REQ-023 SHALL hold out_act, out_nz and out_sat stable while in HOLD and out_ready=0.
REQ-024 SHALL, in HOLD with out_ready=1, complete the output handshake and return to COLLECT on the next cycle; in_ready=1 from that cycle.
REQ-025 SHALL block inputs during HOLD, because in_ready=0; in_valid during HOLD is ignored and no data is lost or overwritten.
REQ-026 SHALL leave out_act, out_nz and out_sat at their last values while in COLLECT; only out_valid qualifies them.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, set state=COLLECT, cnt=0, out_act=0, out_nz=0, out_sat=0 and out_valid=0, with in_ready=1 on the following cycle.
REQ-028 SHALL give reset priority over any simultaneous handshake.
REQ-029 SHALL discard a partially filled vector on reset mid-fill; the next 8 handshakes form a fresh vector starting at slot 0.

Verification
REQ-030 SHALL cover reset check: assert reset 2 cycles -> out_valid=0, in_ready=1, out_act=0, out_nz=0, out_sat=0.
REQ-031 SHALL cover the basic vector: SHIFT=2, bias=0, neurons 100,-50,0,4,3,1023,2047,-2048 -> out_act slots 25,0,0,1,0,255,255,0; out_nz=8'b01101001; out_sat=8'b01000000; out_valid exactly 1 cycle after the 8th handshake.
REQ-032 SHALL cover bias extremes: in_neuron=-2048 with in_bias=-2048 -> slot 0; in_neuron=2047 with in_bias=2047 -> slot 255 with sat=1; both confirm 13-bit sum with no wrap.
REQ-033 SHALL cover backpressure: vector complete, out_ready=0 for 5 cycles, in_valid=1 throughout -> in_ready=0, outputs stable, no slot overwritten; out_ready=1 -> in_ready=1 next cycle.
REQ-034 SHALL cover reset mid-fill: 5 handshakes, reset 1 cycle, then 8 new handshakes -> output contains only the 8 new values, in order.
REQ-035 SHALL cover back-to-back operation: out_ready tied 1, in_valid tied 1 for 32 cycles -> out_valid pulses exactly once per 9 cycles (8 COLLECT + 1 HOLD).

Source files
------------

// File: rtl/relu_pack8.sv
// relu_pack8: bias-add, ReLU, requantize and clip each neuron result, then
// pack eight results into one activation vector with nonzero/saturation maps.
module relu_pack8 #(
  parameter int SHIFT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [11:0]  in_neuron,
  input  logic signed [11:0]  in_bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [71:0]         out_act,
  output logic [7:0]          out_nz,
  output logic [7:0]          out_sat
);

  // state   | meaning
  // COLLECT | accepting neuron results into slot cnt (in_ready=1)
  // HOLD    | full vector presented, waiting for out_ready (out_valid=1)
  typedef enum logic {COLLECT, HOLD} state_t;

  state_t      state;
  logic [2:0]  cnt;

  logic [12:0] sum;
  logic [11:0] relu;
  logic [11:0] q;
  logic [8:0]  act;
  logic        sat;
  logic        nz;

  // Activation datapath: 13-bit sum cannot wrap, and the shift runs on a
  // non-negative value, so a logical shift truncates toward zero.
  always_comb begin
    sum  = {in_neuron[11], in_neuron} + {in_bias[11], in_bias};
    relu = sum[12] ? 12'd0 : sum[11:0];
    q    = relu >> SHIFT;
    sat  = (q > 12'd255);
    act  = sat ? 9'd255 : {1'b0, q[7:0]};
    nz   = (act != 9'd0);
  end

  // Control FSM and slot writes; all handshake-visible outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      cnt       <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_act   <= '0;
      out_nz    <= '0;
      out_sat   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            for (int k = 0; k < 8; k++) begin
              if (cnt == 3'(k)) begin
                out_act[9*k +: 9] <= act;
                out_nz[k]         <= nz;
                out_sat[k]        <= sat;
              end
            end
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_pack8.sv
// Directed bench for relu_pack8 (SHIFT=2): table-driven vectors plus
// hand-written backpressure, reset mid-fill and back-to-back sequences.
module tb_relu_pack8;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] in_neuron;
  logic signed [11:0] in_bias;
  logic               out_valid;
  logic               out_ready;
  logic [71:0]        out_act;
  logic [7:0]         out_nz;
  logic [7:0]         out_sat;

  int cmp_cnt = 0;
  int err_cnt = 0;

  relu_pack8 #(.SHIFT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_neuron (in_neuron),
    .in_bias   (in_bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act),
    .out_nz    (out_nz),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [11:0] neuron;
    logic signed [11:0] bias;
    logic [8:0]         act;
    logic               nz;
    logic               sat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic signed [11:0] n, input logic signed [11:0] b);
    in_neuron = n;
    in_bias   = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic exp_vec(input int base, output logic [71:0] ea, output logic [7:0] en,
                         output logic [7:0] es);
    ea = '0; en = '0; es = '0;
    for (int i = 0; i < 8; i++) begin
      ea[9*i +: 9] = tbl[base+i].act;
      en[i]        = tbl[base+i].nz;
      es[i]        = tbl[base+i].sat;
    end
  endtask

  task automatic run_vec(input int base, input string tag);
    logic [71:0] ea;
    logic [7:0]  en, es;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk({tag, "_valid_before_last"}, 72'(out_valid), 72'(0));
      send(tbl[base+i].neuron, tbl[base+i].bias);
    end
    chk({tag, "_valid_after_last"}, 72'(out_valid), 72'(1));
    chk({tag, "_ready_in_hold"}, 72'(in_ready), 72'(0));
    exp_vec(base, ea, en, es);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_slot%0d", tag, i), 72'(out_act[9*i +: 9]), 72'(ea[9*i +: 9]));
    chk({tag, "_nz"}, 72'(out_nz), 72'(en));
    chk({tag, "_sat"}, 72'(out_sat), 72'(es));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_after_release"}, 72'(out_valid), 72'(0));
    chk({tag, "_ready_after_release"}, 72'(in_ready), 72'(1));
  endtask

  initial begin
    logic [71:0] ea;
    logic [7:0]  en, es;
    int          pulses;
    logic [71:0] b2b_exp;

    // vector A: basic, bias 0
    tbl[0]  = '{12'sd100,   12'sd0, 9'd25,  1'b1, 1'b0};
    tbl[1]  = '{-12'sd50,   12'sd0, 9'd0,   1'b0, 1'b0};
    tbl[2]  = '{12'sd0,     12'sd0, 9'd0,   1'b0, 1'b0};
    tbl[3]  = '{12'sd4,     12'sd0, 9'd1,   1'b1, 1'b0};
    tbl[4]  = '{12'sd3,     12'sd0, 9'd0,   1'b0, 1'b0};
    tbl[5]  = '{12'sd1023,  12'sd0, 9'd255, 1'b1, 1'b0};
    tbl[6]  = '{12'sd2047,  12'sd0, 9'd255, 1'b1, 1'b1};
    tbl[7]  = '{-12'sd2048, 12'sd0, 9'd0,   1'b0, 1'b0};
    // vector B: bias extremes and clip boundary
    tbl[8]  = '{-12'sd2048, -12'sd2048, 9'd0,   1'b0, 1'b0};
    tbl[9]  = '{12'sd2047,  12'sd2047,  9'd255, 1'b1, 1'b1};
    tbl[10] = '{12'sd1020,  12'sd3,     9'd255, 1'b1, 1'b0};
    tbl[11] = '{12'sd1021,  12'sd3,     9'd255, 1'b1, 1'b1};
    tbl[12] = '{12'sd5,     -12'sd10,   9'd0,   1'b0, 1'b0};
    tbl[13] = '{12'sd7,     12'sd0,     9'd1,   1'b1, 1'b0};
    tbl[14] = '{-12'sd1,    12'sd5,     9'd1,   1'b1, 1'b0};
    tbl[15] = '{12'sd0,     -12'sd1,    9'd0,   1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_neuron = '0; in_bias = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", 72'(out_valid), 72'(0));
    chk("rst_ready", 72'(in_ready), 72'(1));
    chk("rst_act",   out_act, 72'(0));
    chk("rst_nz",    72'(out_nz), 72'(0));
    chk("rst_sat",   72'(out_sat), 72'(0));

    run_vec(0, "basic");
    chk("basic_nz_lit",  72'(out_nz),  72'(8'b01101001));
    chk("basic_sat_lit", 72'(out_sat), 72'(8'b01000000));
    release_out("basic");

    run_vec(8, "bias");
    exp_vec(8, ea, en, es);
    in_valid  = 1'b1;
    in_neuron = 12'sd400;
    in_bias   = 12'sd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_ready", c), 72'(in_ready), 72'(0));
      chk($sformatf("bp%0d_valid", c), 72'(out_valid), 72'(1));
      chk($sformatf("bp%0d_act", c), out_act, ea);
      chk($sformatf("bp%0d_nz", c), 72'(out_nz), 72'(en));
      chk($sformatf("bp%0d_sat", c), 72'(out_sat), 72'(es));
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("collect_keeps_act", out_act, ea);

    for (int i = 0; i < 5; i++) send(12'sd400, 12'sd0);
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_act",   out_act, 72'(0));
    chk("midrst_nz",    72'(out_nz), 72'(0));
    chk("midrst_valid", 72'(out_valid), 72'(0));
    chk("midrst_ready", 72'(in_ready), 72'(1));
    run_vec(0, "refill");
    release_out("refill");

    b2b_exp = '0;
    for (int i = 0; i < 8; i++) b2b_exp[9*i +: 9] = 9'(i + 1);
    pulses    = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bias   = 12'sd0;
    for (int e = 1; e <= 32; e++) begin
      in_neuron = 12'(4 * e);
      @(posedge clk);
      #1;
      if (out_valid) begin
        chk($sformatf("b2b_pulse%0d_edge", pulses), 72'(e), 72'(8 + 9 * pulses));
        if (pulses == 0) chk("b2b_first_act", out_act, b2b_exp);
        pulses++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_pulse_count", 72'(pulses), 72'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
